// File: rtl/spill_aligner_if.sv
// Fetch-side bundle for the spill aligner: IFU/decode inputs and the merged-instruction outputs.
// The master drives fetch inputs (IFU model or bench); the slave is the aligner itself.
interface spill_aligner_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 32
);
    logic            StallD;
    logic            FlushD;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCNextF;
    logic [31:0]     InstrRawF;
    logic            IFUCacheBusStallF;
    logic            ITLBMissF;
    logic            InstrAccessFaultF;
    logic            CacheableF;
    logic [XLEN-1:0] PCSpillNextF;
    logic [XLEN-1:0] PCSpillF;
    logic            SelSpillNextF;
    logic [31:0]     PostSpillInstrRawF;
    logic            CompressedF;
    logic            SpillFaultF;
    logic [CNTW-1:0] SpillCount;

    modport master (
        output StallD, FlushD, PCF, PCNextF, InstrRawF, IFUCacheBusStallF,
               ITLBMissF, InstrAccessFaultF, CacheableF,
        input  PCSpillNextF, PCSpillF, SelSpillNextF, PostSpillInstrRawF,
               CompressedF, SpillFaultF, SpillCount
    );

    modport slave (
        input  StallD, FlushD, PCF, PCNextF, InstrRawF, IFUCacheBusStallF,
               ITLBMissF, InstrAccessFaultF, CacheableF,
        output PCSpillNextF, PCSpillF, SelSpillNextF, PostSpillInstrRawF,
               CompressedF, SpillFaultF, SpillCount
    );
endinterface

// File: rtl/spill_aligner.sv
// Joins a 32-bit instruction that straddles a line (cacheable) or bus word (uncached)
// boundary by fetching the upper halfword in a second access and merging it.
//
// state | meaning
// READY | normal fetch, output is the raw fetch word
// SPILL | second-half fetch outstanding or returning this cycle
// HOLD  | merged instruction held while decode is stalled
module spill_aligner #(
    parameter int XLEN      = 32,
    parameter int LINEBYTES = 64,
    parameter int BUSBYTES  = XLEN / 8,
    parameter int CNTW      = 32
) (
    input logic            clk,
    input logic            reset,
    spill_aligner_if.slave bus
);
    localparam int LW = $clog2(LINEBYTES);
    localparam int BW = $clog2(BUSBYTES);

    typedef enum logic [1:0] {READY, SPILL, HOLD} state_t;

    state_t          state, state_next;
    logic [15:0]     first_half;
    logic [XLEN-1:0] spill_pc;
    logic [31:0]     held_instr;
    logic            held_fault;
    logic [CNTW-1:0] spill_count;

    logic [XLEN-1:0] pc_plus2;
    logic            spill_f;
    logic            early_comp;
    logic            data_stall;
    logic            take_spill;
    logic [31:0]     merged_instr;
    logic            spill_fault_now;
    logic            sel_spill_next;
    logic            capture_first;
    logic            capture_hold;
    logic [31:0]     post_instr;

    assign pc_plus2        = bus.PCF + XLEN'(2);
    assign spill_f         = bus.CacheableF ? (&bus.PCF[LW-1:1]) : (&bus.PCF[BW-1:1]);
    assign early_comp      = (bus.InstrRawF[1:0] != 2'b11);
    assign data_stall      = bus.IFUCacheBusStallF | bus.ITLBMissF;
    assign take_spill      = spill_f & ~early_comp & ~data_stall & ~bus.InstrAccessFaultF;
    assign merged_instr    = {bus.InstrRawF[15:0], first_half};
    assign spill_fault_now = bus.InstrAccessFaultF & ~bus.IFUCacheBusStallF;

    always_comb begin
        state_next     = state;
        sel_spill_next = 1'b0;
        capture_first  = 1'b0;
        capture_hold   = 1'b0;
        case (state)
            READY: begin
                sel_spill_next = take_spill;
                if (take_spill) begin
                    state_next    = SPILL;
                    capture_first = 1'b1;
                end
            end
            SPILL: begin
                if (data_stall) begin
                    sel_spill_next = 1'b1;
                end else if (bus.StallD) begin
                    state_next   = HOLD;
                    capture_hold = 1'b1;
                end else begin
                    state_next = READY;
                end
            end
            HOLD: begin
                if (!bus.StallD) state_next = READY;
            end
            default: state_next = READY;
        endcase
        // Flush overrides everything, including captures that would otherwise happen.
        if (bus.FlushD) begin
            state_next    = READY;
            capture_first = 1'b0;
            capture_hold  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= READY;
            first_half  <= '0;
            spill_pc    <= '0;
            held_instr  <= '0;
            held_fault  <= 1'b0;
            spill_count <= '0;
        end else begin
            state <= state_next;
            if (capture_first) begin
                first_half <= bus.InstrRawF[15:0];
                spill_pc   <= pc_plus2;
                if (spill_count != {CNTW{1'b1}}) spill_count <= spill_count + CNTW'(1);
            end
            if (capture_hold) begin
                held_instr <= merged_instr;
                held_fault <= spill_fault_now;
            end
        end
    end

    always_comb begin
        post_instr      = bus.InstrRawF;
        bus.SpillFaultF = 1'b0;
        case (state)
            SPILL: begin
                post_instr      = merged_instr;
                bus.SpillFaultF = spill_fault_now;
            end
            HOLD: begin
                post_instr      = held_instr;
                bus.SpillFaultF = held_fault;
            end
            default: begin
                post_instr      = bus.InstrRawF;
                bus.SpillFaultF = 1'b0;
            end
        endcase
    end

    assign bus.SelSpillNextF      = sel_spill_next;
    assign bus.PCSpillNextF       = (sel_spill_next & ~bus.FlushD) ? pc_plus2 : bus.PCNextF;
    assign bus.PCSpillF           = (state == READY) ? bus.PCF : spill_pc;
    assign bus.PostSpillInstrRawF = post_instr;
    assign bus.CompressedF        = (post_instr[1:0] != 2'b11);
    assign bus.SpillCount         = spill_count;
endmodule

// File: tb/tb_spill_aligner.sv
// Directed vectors drive the aligner; expected outputs go to a queue checked mid-cycle by a monitor.
module tb_spill_aligner;
    localparam logic [31:0] PN = 32'h1111_1110;

    typedef struct {
        int          idx;
        logic        sel;
        logic [31:0] psn;
        logic [31:0] ps;
        logic [31:0] post;
        logic        comp;
        logic        flt;
        logic [31:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   fails;
    int   vec;
    exp_t exp_q[$];

    spill_aligner_if #(.XLEN(32), .CNTW(32)) bus ();
    spill_aligner_if #(.XLEN(32), .CNTW(2))  bus2 ();

    spill_aligner #(.XLEN(32), .LINEBYTES(64), .BUSBYTES(4), .CNTW(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    spill_aligner #(.XLEN(32), .LINEBYTES(64), .BUSBYTES(4), .CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    assign bus2.StallD            = bus.StallD;
    assign bus2.FlushD            = bus.FlushD;
    assign bus2.PCF               = bus.PCF;
    assign bus2.PCNextF           = bus.PCNextF;
    assign bus2.InstrRawF         = bus.InstrRawF;
    assign bus2.IFUCacheBusStallF = bus.IFUCacheBusStallF;
    assign bus2.ITLBMissF         = bus.ITLBMissF;
    assign bus2.InstrAccessFaultF = bus.InstrAccessFaultF;
    assign bus2.CacheableF        = bus.CacheableF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("SelSpillNextF",      e.idx, {31'b0, bus.SelSpillNextF}, {31'b0, e.sel});
            chk("PCSpillNextF",       e.idx, bus.PCSpillNextF, e.psn);
            chk("PCSpillF",           e.idx, bus.PCSpillF, e.ps);
            chk("PostSpillInstrRawF", e.idx, bus.PostSpillInstrRawF, e.post);
            chk("CompressedF",        e.idx, {31'b0, bus.CompressedF}, {31'b0, e.comp});
            chk("SpillFaultF",        e.idx, {31'b0, bus.SpillFaultF}, {31'b0, e.flt});
            chk("SpillCount",         e.idx, bus.SpillCount, e.cnt);
            chk("SpillCount_cntw2",   e.idx, {30'b0, bus2.SpillCount}, {30'b0, e.cnt2});
        end
    end

    // One cycle: apply inputs just after the rising edge, optionally pulse reset mid-cycle,
    // then queue what the outputs must look like at the following falling edge.
    task automatic step(
        input logic [31:0] pcf, input logic [31:0] instr, input logic cach,
        input logic sd, input logic fl, input logic bs, input logic itlb, input logic flt, input logic mrst,
        input logic e_sel, input logic [31:0] e_psn, input logic [31:0] e_ps, input logic [31:0] e_post,
        input logic e_comp, input logic e_flt, input logic [31:0] e_cnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset                 = 1'b0;
        bus.PCF               = pcf;
        bus.InstrRawF         = instr;
        bus.CacheableF        = cach;
        bus.StallD            = sd;
        bus.FlushD            = fl;
        bus.IFUCacheBusStallF = bs;
        bus.ITLBMissF         = itlb;
        bus.InstrAccessFaultF = flt;
        if (mrst) begin
            #1 reset = 1'b1;
        end
        vec++;
        e.idx  = vec;
        e.sel  = e_sel;
        e.psn  = e_psn;
        e.ps   = e_ps;
        e.post = e_post;
        e.comp = e_comp;
        e.flt  = e_flt;
        e.cnt  = e_cnt;
        e.cnt2 = (e_cnt > 32'd3) ? 2'd3 : e_cnt[1:0];
        exp_q.push_back(e);
    endtask

    initial begin
        total = 0;
        fails = 0;
        vec   = 0;
        reset = 1'b1;
        bus.PCF               = '0;
        bus.PCNextF           = PN;
        bus.InstrRawF         = '0;
        bus.CacheableF        = 1'b1;
        bus.StallD            = 1'b0;
        bus.FlushD            = 1'b0;
        bus.IFUCacheBusStallF = 1'b0;
        bus.ITLBMissF         = 1'b0;
        bus.InstrAccessFaultF = 1'b0;
        repeat (2) @(posedge clk);

        //    pcf           instr         c  sd fl bs it ft mr | sel psn           ps            post          cp flt cnt
        step(32'h8000_003E, 32'hAAAA_0513, 1, 0, 0, 1, 0, 0, 0,  0, PN,           32'h8000_003E, 32'hAAAA_0513, 0, 0, 0);
        step(32'h8000_003E, 32'hAAAA_0513, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0040, 32'h8000_003E, 32'hAAAA_0513, 0, 0, 0);
        step(32'h8000_0040, 32'h1234_0050, 1, 0, 0, 0, 0, 0, 0,  0, PN,           32'h8000_0040, 32'h0050_0513, 0, 0, 1);
        step(32'h8000_003E, 32'h0000_0001, 1, 0, 0, 0, 0, 0, 0,  0, PN,           32'h8000_003E, 32'h0000_0001, 1, 0, 1);
        step(32'h0000_1002, 32'h0000_0513, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_1004, 32'h0000_1002, 32'h0000_0513, 0, 0, 1);
        step(32'h0000_1004, 32'h0000_0050, 0, 0, 0, 0, 0, 0, 0,  0, PN,           32'h0000_1004, 32'h0050_0513, 0, 0, 2);
        step(32'h0000_1002, 32'h0000_0513, 1, 0, 0, 0, 0, 0, 0,  0, PN,           32'h0000_1002, 32'h0000_0513, 0, 0, 2);
        // spill that waits on the bus/TLB, then lands into a decode stall
        step(32'h8000_003E, 32'hAAAA_0513, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0040, 32'h8000_003E, 32'hAAAA_0513, 0, 0, 2);
        step(32'h8000_003E, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 0, 0,  1, 32'h8000_0040, 32'h8000_0040, 32'hBEEF_0513, 0, 0, 3);
        step(32'h8000_003E, 32'hDEAD_BEEF, 1, 0, 0, 0, 1, 0, 0,  1, 32'h8000_0040, 32'h8000_0040, 32'hBEEF_0513, 0, 0, 3);
        step(32'h8000_003E, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 0, 0,  1, 32'h8000_0040, 32'h8000_0040, 32'hBEEF_0513, 0, 0, 3);
        step(32'h8000_0040, 32'hFFFF_0050, 1, 1, 0, 0, 0, 0, 0,  0, PN,           32'h8000_0040, 32'h0050_0513, 0, 0, 3);
        step(32'h8000_0040, 32'hDEAD_BEEF, 1, 1, 0, 1, 0, 1, 0,  0, PN,           32'h8000_0040, 32'h0050_0513, 0, 0, 3);
        step(32'h8000_0040, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 1, 0,  0, PN,           32'h8000_0040, 32'h0050_0513, 0, 0, 3);
        // flush in SPILL, then flush together with a would-be spill in READY
        step(32'h8000_003E, 32'hAAAA_0513, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0040, 32'h8000_003E, 32'hAAAA_0513, 0, 0, 3);
        step(32'h8000_003E, 32'h1234_5678, 1, 0, 1, 1, 0, 0, 0,  1, PN,           32'h8000_0040, 32'h5678_0513, 0, 0, 4);
        step(32'h8000_003E, 32'hAAAA_0513, 1, 0, 1, 0, 0, 0, 0,  1, PN,           32'h8000_003E, 32'hAAAA_0513, 0, 0, 4);
        step(32'h8000_003E, 32'h0000_7777, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0040, 32'h8000_003E, 32'h0000_7777, 0, 0, 4);
        // faulting second half, held through a decode stall
        step(32'h8000_0040, 32'h0000_0050, 1, 1, 0, 0, 0, 1, 0,  0, PN,           32'h8000_0040, 32'h0050_7777, 0, 1, 5);
        step(32'h8000_0040, 32'h0000_0000, 1, 1, 0, 0, 0, 0, 0,  0, PN,           32'h8000_0040, 32'h0050_7777, 0, 1, 5);
        step(32'h8000_0040, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 0,  0, PN,           32'h8000_0040, 32'h0050_7777, 0, 1, 5);
        // async reset in the middle of a SPILL cycle
        step(32'h8000_003E, 32'hAAAA_0513, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0040, 32'h8000_003E, 32'hAAAA_0513, 0, 0, 5);
        step(32'h8000_0044, 32'h0000_0050, 1, 1, 0, 0, 0, 0, 1,  0, PN,           32'h8000_0044, 32'h0000_0050, 1, 0, 0);
        // PC wrap on the spill address
        step(32'hFFFF_FFFE, 32'h0000_0513, 1, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0513, 0, 0, 0);
        step(32'h0000_0004, 32'h0000_0050, 1, 0, 0, 0, 0, 0, 0,  0, PN,           32'h0000_0000, 32'h0050_0513, 0, 0, 1);
        step(32'h0000_0100, 32'h0000_0013, 1, 0, 0, 0, 0, 0, 0,  0, PN,           32'h0000_0100, 32'h0000_0013, 0, 0, 1);

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end
endmodule
